// File: rtl/rob_marker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rob_marker_pkg
// Brief   : Shared constants, types and helpers for the ROB marker decoder.
// Revision: 1.0 - initial release
// ============================================================================
package rob_marker_pkg;

    localparam logic [19:0] MARKER_LOW20 = 20'h02013;

    localparam logic [3:0] VCTM_START  = 4'd0;
    localparam logic [3:0] VCTM_END    = 4'd1;
    localparam logic [3:0] DELAY_START = 4'd2;
    localparam logic [3:0] DELAY_END   = 4'd3;
    localparam logic [3:0] TEXE_START  = 4'd4;
    localparam logic [3:0] TEXE_END    = 4'd5;
    localparam logic [3:0] LEAK_START  = 4'd6;
    localparam logic [3:0] LEAK_END    = 4'd7;
    localparam logic [3:0] INIT_START  = 4'd8;
    localparam logic [3:0] INIT_END    = 4'd9;
    localparam logic [3:0] BIM_START   = 4'd10;
    localparam logic [3:0] BIM_END     = 4'd11;
    localparam logic [3:0] TRAIN_START = 4'd12;
    localparam logic [3:0] TRAIN_END   = 4'd13;

    // Record fields are sized for the widest supported configuration
    localparam int c_EVT_LANE_W = 4;
    localparam int c_EVT_TIME_W = 64;

    typedef enum logic [2:0] {
        PH_VCTM  = 3'd0,
        PH_DELAY = 3'd1,
        PH_TEXE  = 3'd2,
        PH_LEAK  = 3'd3,
        PH_INIT  = 3'd4,
        PH_BIM   = 3'd5,
        PH_TRAIN = 3'd6
    } phase_e;

    typedef struct packed {
        logic [3:0]              code;
        logic [c_EVT_LANE_W-1:0] lane;
        logic [c_EVT_TIME_W-1:0] tstamp;
    } evt_rec_t;

    function automatic logic is_marker(input logic [31:0] inst);
        return (inst[19:0] == MARKER_LOW20) && (inst[31:24] == 8'h00) &&
               (inst[23:20] <= TRAIN_END);
    endfunction

    function automatic phase_e code_phase(input logic [3:0] code);
        return phase_e'(code[3:1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_marker_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rob_marker_fifo
// Brief   : Multi-push, single-pop event FIFO with a post-pop free count.
// Revision: 1.0 - initial release
// ============================================================================
module rob_marker_fifo
    import rob_marker_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int PUSH_W   = 2,
    localparam int c_ADDR_W = $clog2(DEPTH),
    localparam int c_CNT_W  = $clog2(DEPTH + 1),
    localparam int c_NUM_W  = $clog2(PUSH_W + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [c_NUM_W-1:0]       i_push_num,
    input  evt_rec_t [PUSH_W-1:0]    i_push_data,
    input  logic                     i_pop_ready,
    output logic                     o_head_valid,
    output evt_rec_t                 o_head,
    output logic [c_CNT_W-1:0]       o_free_cnt
);

    evt_rec_t              r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  w_pop;
    logic [c_ADDR_W-1:0]   w_wr_idx [PUSH_W];

    assign o_head_valid = (r_count != '0);
    assign o_head       = r_mem[r_rd_ptr];
    assign w_pop        = o_head_valid && i_pop_ready;
    // A same-cycle pop frees its slot for this cycle's pushes
    assign o_free_cnt   = c_CNT_W'(DEPTH) - r_count + c_CNT_W'(w_pop);

    for (genvar k = 0; k < PUSH_W; k++) begin : g_wr_idx
        assign w_wr_idx[k] = r_wr_ptr + c_ADDR_W'(k);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int k = 0; k < PUSH_W; k++) begin
                if (k < int'(i_push_num)) begin
                    r_mem[w_wr_idx[k]] <= i_push_data[k];
                end
            end
            r_wr_ptr <= r_wr_ptr + c_ADDR_W'(i_push_num);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(i_push_num) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_marker_decoder.sv
`default_nettype none
// ============================================================================
// Module  : rob_marker_decoder
// Brief   : Detects slti x0,x0,imm markers on ROB commit lanes, timestamps and
//           queues them, and tracks the START/END test phase.
// Revision: 1.0 - initial release
// ============================================================================
module rob_marker_decoder
    import rob_marker_pkg::*;
#(
    parameter  int COMMIT_WIDTH = 2,
    parameter  int FIFO_DEPTH   = 8,
    parameter  int TS_WIDTH     = 40,
    parameter  int DROP_WIDTH   = 16,
    localparam int c_LANE_W     = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [COMMIT_WIDTH-1:0]   commit_valid,
    input  logic [32*COMMIT_WIDTH-1:0] commit_inst,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [3:0]                evt_code,
    output logic [c_LANE_W-1:0]       evt_lane,
    output logic [TS_WIDTH-1:0]       evt_time,
    output logic [2:0]                cur_phase,
    output logic                      in_phase,
    output logic                      seq_err,
    output logic                      overflow,
    output logic [DROP_WIDTH-1:0]     drop_cnt
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_NUM_W = $clog2(COMMIT_WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    logic [TS_WIDTH-1:0]          r_cycle;
    state_e                       r_state;
    state_e                       w_state_nxt;
    phase_e                       r_phase;
    phase_e                       w_phase_nxt;
    logic                         r_seq_err;
    logic                         w_err_nxt;
    logic                         r_overflow;
    logic [DROP_WIDTH-1:0]        r_drop_cnt;
    logic [DROP_WIDTH:0]          w_drop_sum;

    logic [COMMIT_WIDTH-1:0]      w_hit;
    logic [3:0]                   w_code [COMMIT_WIDTH];
    evt_rec_t [COMMIT_WIDTH-1:0]  w_push_data;
    logic [c_NUM_W-1:0]           w_push_num;
    logic [c_NUM_W-1:0]           w_drop_num;
    int                           w_slot;
    int                           w_drops;
    logic [c_CNT_W-1:0]           w_free;
    logic                         w_head_valid;
    evt_rec_t                     w_head;

    for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_lane
        logic [31:0] w_inst;
        assign w_inst    = commit_inst[32*i +: 32];
        assign w_hit[i]  = commit_valid[i] && is_marker(w_inst);
        assign w_code[i] = w_inst[23:20];
    end

    // Lanes claim free slots in ascending order; the remainder are dropped
    always_comb begin
        w_push_data = '0;
        w_slot      = 0;
        w_drops     = 0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (w_hit[i]) begin
                if (w_slot < int'(w_free)) begin
                    w_push_data[w_slot] = '{code:   w_code[i],
                                            lane:   c_EVT_LANE_W'(i),
                                            tstamp: c_EVT_TIME_W'(r_cycle)};
                    w_slot = w_slot + 1;
                end else begin
                    w_drops = w_drops + 1;
                end
            end
        end
        w_push_num = c_NUM_W'(w_slot);
        w_drop_num = c_NUM_W'(w_drops);
    end

    // Every detected marker steps the phase tracker, queued or not
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_err_nxt   = r_seq_err;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (w_hit[i]) begin
                if (!w_code[i][0]) begin
                    if (w_state_nxt == ST_ACTIVE) begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = ST_ACTIVE;
                    w_phase_nxt = code_phase(w_code[i]);
                end else begin
                    if ((w_state_nxt != ST_ACTIVE) ||
                        (w_phase_nxt != code_phase(w_code[i]))) begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_WIDTH + 1)'(w_drop_num);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle    <= '0;
            r_state    <= ST_IDLE;
            r_phase    <= PH_VCTM;
            r_seq_err  <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_cycle   <= r_cycle + TS_WIDTH'(1);
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_seq_err <= w_err_nxt;
            if (w_drop_num != '0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[DROP_WIDTH] ? '1 : w_drop_sum[DROP_WIDTH-1:0];
            end
        end
    end

    rob_marker_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .PUSH_W (COMMIT_WIDTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .i_push_num   (w_push_num),
        .i_push_data  (w_push_data),
        .i_pop_ready  (evt_ready),
        .o_head_valid (w_head_valid),
        .o_head       (w_head),
        .o_free_cnt   (w_free)
    );

    assign evt_valid = w_head_valid;
    assign evt_code  = w_head.code;
    assign evt_lane  = w_head.lane[c_LANE_W-1:0];
    assign evt_time  = w_head.tstamp[TS_WIDTH-1:0];
    assign cur_phase = r_phase;
    assign in_phase  = (r_state == ST_ACTIVE);
    assign seq_err   = r_seq_err;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

    if (TS_WIDTH < c_EVT_TIME_W) begin : g_time_pad
        logic w_unused_time;
        assign w_unused_time = ^w_head.tstamp[c_EVT_TIME_W-1:TS_WIDTH];
    end

    if (c_LANE_W < c_EVT_LANE_W) begin : g_lane_pad
        logic w_unused_lane;
        assign w_unused_lane = ^w_head.lane[c_EVT_LANE_W-1:c_LANE_W];
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_marker_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_marker_decoder
// Brief   : Self-checking bench: directed vector table, corner sequences and
//           randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rob_marker_decoder;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  commit_valid;
    logic [63:0] commit_inst;
    logic        evt_ready;
    logic        evt_valid;
    logic [3:0]  evt_code;
    logic [0:0]  evt_lane;
    logic [39:0] evt_time;
    logic [2:0]  cur_phase;
    logic        in_phase;
    logic        seq_err;
    logic        overflow;
    logic [15:0] drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rob_marker_decoder #(
        .COMMIT_WIDTH (2),
        .FIFO_DEPTH   (DEPTH),
        .TS_WIDTH     (40),
        .DROP_WIDTH   (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_lane     (evt_lane),
        .evt_time     (evt_time),
        .cur_phase    (cur_phase),
        .in_phase     (in_phase),
        .seq_err      (seq_err),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        int     code;
        int     lane;
        longint t;
    } mrec_t;

    mrec_t  mq[$];
    longint m_cyc;
    bit     m_act;
    int     m_ph;
    bit     m_err;
    bit     m_ovf;
    int     m_drop;

    function automatic bit ref_is_marker(logic [31:0] w);
        return ((w & 32'hFF0F_FFFF) == 32'h0000_2013) && (w[23:20] < 4'd14);
    endfunction

    function automatic logic [31:0] mk(int code);
        logic [3:0] c;
        c = 4'(code);
        return {8'h00, c, 20'h02013};
    endfunction

    function void model_reset();
        mq.delete();
        m_cyc  = 0;
        m_act  = 0;
        m_ph   = 0;
        m_err  = 0;
        m_ovf  = 0;
        m_drop = 0;
    endfunction

    function void model_apply(logic [1:0] v, logic [31:0] i0, logic [31:0] i1, logic rdy);
        int          free;
        logic [31:0] w;
        int          code;
        mrec_t       r;
        if (mq.size() > 0 && rdy) r = mq.pop_front();
        free = DEPTH - mq.size();
        for (int l = 0; l < 2; l++) begin
            w = (l == 0) ? i0 : i1;
            if (v[l] && ref_is_marker(w)) begin
                code = int'(w[23:20]);
                if (free > 0) begin
                    mq.push_back('{code, l, m_cyc});
                    free--;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                if (code % 2 == 0) begin
                    if (m_act) m_err = 1;
                    m_act = 1;
                    m_ph  = code / 2;
                end else begin
                    if (!m_act || m_ph != code / 2) m_err = 1;
                    m_act = 0;
                end
            end
        end
        m_cyc = (m_cyc + 1) % (longint'(1) << 40);
    endfunction

    // ---------------- checking helpers ----------------
    function void chk(string name, longint act, longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endfunction

    function void check_model(int c);
        chk($sformatf("rnd%0d_valid", c), evt_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk($sformatf("rnd%0d_code", c), evt_code, mq[0].code);
            chk($sformatf("rnd%0d_lane", c), evt_lane, mq[0].lane);
            chk($sformatf("rnd%0d_time", c), evt_time, mq[0].t);
        end
        chk($sformatf("rnd%0d_in_phase", c), in_phase, m_act);
        if (m_act) chk($sformatf("rnd%0d_cur_phase", c), cur_phase, m_ph);
        chk($sformatf("rnd%0d_seq_err", c), seq_err, m_err);
        chk($sformatf("rnd%0d_overflow", c), overflow, m_ovf);
        chk($sformatf("rnd%0d_drop_cnt", c), drop_cnt, m_drop);
    endfunction

    function void check_cleared(string tag);
        chk({tag, "_valid"}, evt_valid, 0);
        chk({tag, "_code"}, evt_code, 0);
        chk({tag, "_lane"}, evt_lane, 0);
        chk({tag, "_time"}, evt_time, 0);
        chk({tag, "_cur_phase"}, cur_phase, 0);
        chk({tag, "_in_phase"}, in_phase, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        commit_valid = 2'b00;
        evt_ready    = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        model_reset();
    endtask

    // One cycle: drive at negedge, outputs settle after the next posedge
    task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic rdy);
        @(negedge clock);
        commit_valid = v;
        commit_inst  = {i1, i0};
        evt_ready    = rdy;
        model_apply(v, i0, i1, rdy);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        int          sel;
        logic [31:0] w;
        sel = $urandom_range(0, 9);
        if (sel < 6) begin
            w = {8'h00, 4'($urandom_range(0, 15)), 20'h02013};
        end else if (sel < 8) begin
            w = {8'h00, 4'($urandom_range(0, 13)), 20'h02013};
            w = w ^ (32'h1 << $urandom_range(0, 31));
        end else begin
            w = $urandom();
        end
        return w;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  v;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        rdy;
        logic        ev;
        int          code;
        int          lane;
        longint      tm;
        logic        inph;
        int          ph;
        logic        err;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[1]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[2]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[3]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[4]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[5]  = '{2'b01, 32'h00002013, 32'h0, 1'b1, 1'b1, 0, 0, 5, 1'b1, 0, 1'b0};
        tbl[6]  = '{2'b01, 32'h00102013, 32'h0, 1'b1, 1'b1, 1, 0, 6, 1'b0, 0, 1'b0};
        tbl[7]  = '{2'b11, 32'h00202013, 32'h00302013, 1'b1, 1'b1, 2, 0, 7, 1'b0, 0, 1'b0};
        tbl[8]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 3, 1, 7, 1'b0, 0, 1'b0};
        tbl[9]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[10] = '{2'b11, 32'h00e02013, 32'h00002033, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[11] = '{2'b00, 32'h00002013, 32'h00002013, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[12] = '{2'b10, 32'h00002013, 32'h00802013, 1'b1, 1'b1, 8, 1, 12, 1'b1, 4, 1'b0};
        tbl[13] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 4, 1'b0};
        tbl[14] = '{2'b01, 32'h00b02013, 32'h0, 1'b1, 1'b1, 11, 0, 14, 1'b0, 0, 1'b1};
        tbl[15] = '{2'b01, 32'h00a02013, 32'h0, 1'b0, 1'b1, 11, 0, 14, 1'b1, 5, 1'b1};
        tbl[16] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 10, 0, 15, 1'b1, 5, 1'b1};
        tbl[17] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 5, 1'b1};

        commit_valid = 2'b00;
        commit_inst  = '0;
        evt_ready    = 1'b0;
        do_reset();
        check_cleared("reset");

        for (int k = 0; k < 18; k++) begin
            step(tbl[k].v, tbl[k].i0, tbl[k].i1, tbl[k].rdy);
            chk($sformatf("tbl%0d_valid", k), evt_valid, tbl[k].ev);
            if (tbl[k].ev) begin
                chk($sformatf("tbl%0d_code", k), evt_code, tbl[k].code);
                chk($sformatf("tbl%0d_lane", k), evt_lane, tbl[k].lane);
                chk($sformatf("tbl%0d_time", k), evt_time, tbl[k].tm);
            end
            chk($sformatf("tbl%0d_in_phase", k), in_phase, tbl[k].inph);
            if (tbl[k].inph) chk($sformatf("tbl%0d_cur_phase", k), cur_phase, tbl[k].ph);
            chk($sformatf("tbl%0d_seq_err", k), seq_err, tbl[k].err);
        end

        // Overflow: ten markers with the consumer stalled, then full-FIFO pop+push
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(2'b01, mk(k), 32'h0, 1'b0);
            chk($sformatf("ovf%0d_drop_cnt", k), drop_cnt, (k < 8) ? 0 : k - 7);
            chk($sformatf("ovf%0d_overflow", k), overflow, (k < 8) ? 0 : 1);
        end
        chk("ovf_head_valid", evt_valid, 1);
        chk("ovf_head_code", evt_code, 0);
        chk("ovf_head_time", evt_time, 0);
        step(2'b10, 32'h0, mk(12), 1'b1);
        chk("full_swap_drop_cnt", drop_cnt, 2);
        chk("full_swap_in_phase", in_phase, 1);
        chk("full_swap_cur_phase", cur_phase, 6);
        chk("full_swap_seq_err", seq_err, 0);
        begin
            int exp_codes [8];
            exp_codes = '{1, 2, 3, 4, 5, 6, 7, 12};
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("drain%0d_valid", j), evt_valid, 1);
                chk($sformatf("drain%0d_code", j), evt_code, exp_codes[j]);
                chk($sformatf("drain%0d_time", j), evt_time,
                    (exp_codes[j] == 12) ? 10 : exp_codes[j]);
                step(2'b00, 32'h0, 32'h0, 1'b1);
            end
        end
        chk("drain_empty", evt_valid, 0);

        // Lone END from IDLE
        do_reset();
        step(2'b01, 32'h00702013, 32'h0, 1'b1);
        chk("lone_end_seq_err", seq_err, 1);
        chk("lone_end_in_phase", in_phase, 0);
        chk("lone_end_valid", evt_valid, 1);
        chk("lone_end_code", evt_code, 7);

        // Asynchronous reset with three events queued and a phase open
        step(2'b01, mk(4), 32'h0, 1'b0);
        step(2'b10, 32'h0, mk(6), 1'b0);
        chk("pre_rst_in_phase", in_phase, 1);
        chk("pre_rst_cur_phase", cur_phase, 3);
        chk("pre_rst_valid", evt_valid, 1);
        chk("pre_rst_code", evt_code, 7);
        #2 reset = 1'b1;
        #1;
        check_cleared("async_rst");
        do_reset();
        step(2'b01, mk(0), 32'h0, 1'b1);
        chk("post_rst_valid", evt_valid, 1);
        chk("post_rst_code", evt_code, 0);
        chk("post_rst_time", evt_time, 0);

        // Randomized traffic with alternating back-pressure
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [1:0]  v;
            logic [31:0] i0;
            logic [31:0] i1;
            logic        rdy;
            v   = 2'($urandom_range(0, 3));
            i0  = rand_inst();
            i1  = rand_inst();
            rdy = ($urandom_range(0, 99) < (((c / 50) % 2 == 1) ? 85 : 20));
            step(v, i0, i1, rdy);
            check_model(c);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_marker_decoder.md
Name: rob_marker_decoder

Overview:
- Taps the ROB commit lanes of one core and detects marker instructions of the form `slti x0,x0,imm`.
- Converts each marker into a timestamped event record and buffers the records in a multi-write FIFO.
- Presents the records over a valid/ready stream to the simulation sync monitor, which logs them.
- Also tracks the current test phase in commit order and flags malformed START/END sequences.

Parameters:
- COMMIT_WIDTH, 2: number of ROB commit lanes sampled per cycle.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥ COMMIT_WIDTH.
- TS_WIDTH, 40: cycle-counter and timestamp width.
- DROP_WIDTH, 16: width of the saturating dropped-event counter.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  COMMIT_WIDTH  per-lane commit valid.
- commit_inst  in  32*COMMIT_WIDTH  per-lane instruction word; lane i occupies bits [32i+31:32i].
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts the head.
- evt_code  out  4  marker code, 0..13.
- evt_lane  out  $clog2(COMMIT_WIDTH) (min 1)  lane that committed the marker.
- evt_time  out  TS_WIDTH  cycle stamp taken at commit.
- cur_phase  out  3  phase index, valid when in_phase=1.
- in_phase  out  1  inside a START..END window.
- seq_err  out  1  sticky sequencing error.
- overflow  out  1  sticky; set when any event has been dropped.
- drop_cnt  out  DROP_WIDTH  saturating count of dropped events.

Behaviour:
- Marker detect, per lane, combinational:
  - commit_valid[i] is high;
  - inst[19:0]==20'h02013 and inst[31:24]==0;
  - inst[23:20] ≤ 4'hD.
  - Code = inst[23:20]. Phase = code>>1 (0 VCTM, 1 DELAY, 2 TEXE, 3 LEAK, 4 INIT, 5 BIM, 6 TRAIN). Even code = START, odd code = END.
  - inst[23:20] of 4'hE or 4'hF is not a marker and is ignored.
- Cycle counter:
  - Free-running, reset to 0, increments every cycle, wraps modulo 2^TS_WIDTH.
  - All markers of one cycle are stamped with that cycle's counter value.
- Enqueue:
  - Markers of one cycle are written in ascending lane order, up to the number of free slots.
  - Free slots are counted after this cycle's dequeue, so a pop and a push in the same cycle on a full FIFO succeed.
  - Surplus markers are dropped. Each drop sets overflow and increments drop_cnt, which saturates at all-ones.
- Dequeue:
  - A pop happens when evt_valid && evt_ready.
  - evt_* reflect the head entry, registered, with no combinational path from commit_* to evt_*.
  - Minimum latency is 1 cycle: a marker committed in cycle N appears on evt_valid in cycle N+1.
  - evt_code/evt_lane/evt_time hold stable while evt_valid && !evt_ready.
- Phase FSM:
  - States: IDLE (in_phase=0) and ACTIVE(p) (in_phase=1, cur_phase=p).
  - Driven by every detected marker, including dropped ones, in lane order within a cycle.
  - IDLE + START(p) → ACTIVE(p).
  - ACTIVE(p) + END(p) → IDLE.
  - ACTIVE(p) + START(q) → ACTIVE(q), seq_err set (nesting not allowed).
  - IDLE + END(any) → IDLE, seq_err set.
  - ACTIVE(p) + END(q≠p) → IDLE, seq_err set.
  - Several markers in one cycle are applied sequentially in lane order; outputs show the final state.
- Reset values: FIFO empty; evt_valid=0; evt_code/evt_lane/evt_time=0; cur_phase=0; in_phase=0; seq_err=0; overflow=0; drop_cnt=0; counter=0.
- Reset mid-operation: queued events are discarded and the FSM returns to IDLE.
- Sticky flags are cleared only by reset.

Decomposition:
- Package rob_marker_pkg holds:
  - MARKER_LOW20=20'h02013;
  - the 4-bit code constants: VCTM_START=0 … TRAIN_END=13;
  - a 3-bit phase enum;
  - typedef evt_rec_t {code, lane, time};
  - functions is_marker(inst) and code_phase(code).
- Sub-module: rob_marker_fifo, a parameterized multi-push (≤COMMIT_WIDTH), single-pop FIFO of evt_rec_t with a free-count output. The decoder top holds detect, the counter and the FSM.

Test Plan:
- Lane0 commits 32'h00002013 in cycle 5 with evt_ready=1 → next cycle evt_valid=1, code=0, lane=0, time=5; in_phase=1, cur_phase=0.
- Same cycle, lane0=32'h00202013 and lane1=32'h00302013 → two events in order (code 2, lane 0), then (code 3, lane 1), equal time; final in_phase=0; seq_err=0.
- evt_ready=0, one marker per cycle for 10 cycles with FIFO_DEPTH=8 → 8 queued; overflow=1; drop_cnt=2. Raising evt_ready drains codes in commit order.
- Lone END 32'h00702013 from IDLE → seq_err=1, in_phase=0; event still enqueued with code 7.
- 32'h00e02013, 32'h00002033 and a valid=0 marker → no events, no state change.
- Assert reset while 3 events are queued and in_phase=1 → evt_valid=0, in_phase=0, flags=0 immediately (asynchronous); counter restarts at 0.
